// File: rtl/fir_n_tap_hardware_share.sv
// fir_n_tap_hardware_share: time-multiplexed N-tap FIR with one shared MAC and programmable coefficients.
// Define FIR_ROUND_EN to round half up on the output instead of truncating toward -inf.
module fir_n_tap_hardware_share #(
    parameter int DATA_WIDTH           = 16,
    parameter int COEFF_WIDTH          = 16,
    parameter int COEFF_FRACTION_WIDTH = 15,
    parameter int NUM_TAPS             = 8,
    localparam int OUT_WIDTH  = DATA_WIDTH + COEFF_WIDTH - COEFF_FRACTION_WIDTH + $clog2(NUM_TAPS),
    localparam int ADDR_WIDTH = $clog2(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic signed [DATA_WIDTH-1:0]  i_data,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    input  logic                          i_clear,
    input  logic                          i_coeff_we,
    input  logic [ADDR_WIDTH-1:0]         i_coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] i_coeff_data,
    output logic signed [OUT_WIDTH-1:0]   o_data_sum,
    output logic                          o_data_valid,
    output logic                          o_busy
);
    localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS);
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   x [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0]  h [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]    acc;
    logic [ADDR_WIDTH-1:0]          k;
    logic signed [PROD_WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0]    acc_next;
    logic signed [ACC_WIDTH-1:0]    acc_rnd;

    always_comb begin
        prod     = PROD_WIDTH'(x[k]) * PROD_WIDTH'(h[k]);
        acc_next = acc + ACC_WIDTH'(prod);
`ifdef FIR_ROUND_EN
        acc_rnd  = acc + (ACC_WIDTH'(1) <<< (COEFF_FRACTION_WIDTH - 1));
`else
        acc_rnd  = acc;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            x            <= '{default: '0};
            h            <= '{default: '0};
            acc          <= '0;
            k            <= '0;
            o_data_sum   <= '0;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_data_ready <= 1'b1;
        end else begin
            o_data_valid <= 1'b0;
            // Writes land before the MAC reads h, so a same-cycle accept sees the new value
            if (i_coeff_we && state == IDLE)
                h[i_coeff_addr] <= i_coeff_data;
            if (i_clear) begin
                state        <= IDLE;
                x            <= '{default: '0};
                acc          <= '0;
                k            <= '0;
                o_busy       <= 1'b0;
                o_data_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (i_data_valid) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--)
                            x[i] <= x[i-1];
                        x[0]         <= i_data;
                        acc          <= '0;
                        k            <= '0;
                        state        <= MAC;
                        o_busy       <= 1'b1;
                        o_data_ready <= 1'b0;
                    end
                    MAC: begin
                        acc <= acc_next;
                        k   <= k + 1'b1;
                        if (k == ADDR_WIDTH'(NUM_TAPS - 1))
                            state <= DONE;
                    end
                    DONE: begin
                        o_data_sum   <= OUT_WIDTH'(acc_rnd >>> COEFF_FRACTION_WIDTH);
                        o_data_valid <= 1'b1;
                        state        <= IDLE;
                        o_busy       <= 1'b0;
                        o_data_ready <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fir_n_tap_hardware_share.sv
// tb_fir_n_tap_hardware_share: directed vectors checked against a per-cycle sample-level FIR model.
// Literal expectations switch with FIR_ROUND_EN.
module tb_fir_n_tap_hardware_share;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int F  = 15;
    localparam int OW = DW + CW - F + $clog2(N);
    localparam int AW = $clog2(N);
`ifdef FIR_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic signed [DW-1:0] i_data = '0;
    logic                 i_data_valid = 1'b0;
    logic                 o_data_ready;
    logic                 i_clear = 1'b0;
    logic                 i_coeff_we = 1'b0;
    logic [AW-1:0]        i_coeff_addr = '0;
    logic signed [CW-1:0] i_coeff_data = '0;
    logic signed [OW-1:0] o_data_sum;
    logic                 o_data_valid;
    logic                 o_busy;

    int errors = 0;
    int checks = 0;

    fir_n_tap_hardware_share #(
        .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .COEFF_FRACTION_WIDTH(F), .NUM_TAPS(N)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready), .i_clear(i_clear), .i_coeff_we(i_coeff_we),
        .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data), .o_data_sum(o_data_sum),
        .o_data_valid(o_data_valid), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Sample-level model: history, coefficients and the cycles left until idle
    int     hist [N] = '{default: 0};
    int     coef [N] = '{default: 0};
    int     busy_left = 0;
    int     cyc = 0;
    longint pend = 0;
    longint exp_sum = 0;
    bit     exp_valid = 1'b0;

    function automatic longint fir_out();
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(hist[i]) * longint'(coef[i]);
        if (RND) s += longint'(1) << (F - 1);
        s = s >>> F;
        return longint'($signed(s[OW-1:0]));
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            hist = '{default: 0};
            coef = '{default: 0};
            busy_left = 0;
            exp_sum = 0;
            exp_valid = 1'b0;
        end else begin
            cyc++;
            exp_valid = 1'b0;
            if (busy_left == 0 && i_coeff_we) coef[i_coeff_addr] = int'(i_coeff_data);
            if (i_clear) begin
                hist = '{default: 0};
                busy_left = 0;
            end else if (busy_left == 0) begin
                if (i_data_valid) begin
                    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = int'(i_data);
                    pend = fir_out();
                    busy_left = N + 1;
                end
            end else begin
                busy_left--;
                if (busy_left == 0) begin
                    exp_valid = 1'b1;
                    exp_sum = pend;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        chk("valid", longint'(o_data_valid), longint'(exp_valid));
        chk("ready", longint'(o_data_ready), longint'(busy_left == 0));
        chk("busy", longint'(o_busy), longint'(busy_left != 0));
        chk("sum", longint'(o_data_sum), exp_sum);
    end

    task automatic wcoef(input int a, input int d);
        i_coeff_we = 1'b1;
        i_coeff_addr = AW'(a);
        i_coeff_data = CW'(d);
        @(negedge clk);
        i_coeff_we = 1'b0;
    endtask

    task automatic clr();
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    task automatic send(input int d, output int ac);
        bit done = 1'b0;
        i_data = DW'(d);
        i_data_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            if (o_data_ready) done = 1'b1;
            @(negedge clk);
        end
        ac = cyc;
        i_data_valid = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(input longint lit, input string nm, input int ac);
        bit got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(posedge clk);
            #1;
            if (o_data_valid) begin
                got = 1'b1;
                chk(nm, longint'(o_data_sum), lit);
                chk({nm, "_latency"}, longint'(cyc - ac), longint'(N + 1));
            end
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic no_valid(input string nm);
        int vc = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (o_data_valid) vc++;
        end
        chk(nm, longint'(vc), 0);
        @(negedge clk);
    endtask

    initial begin
        int a, a1, a2, a3;
        repeat (3) @(negedge clk);
        chk("rst_sum", longint'(o_data_sum), 0);
        chk("rst_ready", longint'(o_data_ready), 1);
        chk("rst_busy", longint'(o_busy), 0);
        reset_n = 1'b1;
        @(negedge clk);

        wcoef(0, 4096); wcoef(1, 8192); wcoef(2, 8192); wcoef(3, 4096);
        send(100, a); wait_out(RND ? 13 : 12, "x100", a);
        send(200, a); wait_out(50, "x200", a);
        send(300, a); wait_out(RND ? 113 : 112, "x300", a);
        send(400, a); wait_out(RND ? 188 : 187, "x400", a);

        send(1, a1); send(2, a2); send(3, a3);
        chk("spacing12", longint'(a2 - a1), longint'(N + 2));
        chk("spacing23", longint'(a3 - a2), longint'(N + 2));
        wait_out(51, "cont3", a3);

        send(500, a);
        @(negedge clk);
        wcoef(0, 0);
        wait_out(RND ? 64 : 63, "we_in_mac", a);

        clr();
        wcoef(1, 0); wcoef(2, 0); wcoef(3, 0);
        send(-100, a); wait_out(RND ? -12 : -13, "neg", a);

        i_coeff_we = 1'b1; i_coeff_addr = '0; i_coeff_data = 16'sd8192;
        send(100, a);
        i_coeff_we = 1'b0;
        wait_out(25, "we_with_accept", a);

        wcoef(0, 4096); wcoef(1, 8192);
        send(777, a);
        @(negedge clk); @(negedge clk);
        clr();
        chk("clear_ready", longint'(o_data_ready), 1);
        no_valid("clear_novalid");
        send(100, a); wait_out(RND ? 13 : 12, "after_clear", a);

        for (int i = 0; i < N; i++) wcoef(i, 32767);
        clr();
        for (int i = 0; i < N; i++) send(32767, a);
        wait_out(262128, "fullscale", a);

        send(5, a);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_sum", longint'(o_data_sum), 0);
        chk("midrst_valid", longint'(o_data_valid), 0);
        chk("midrst_ready", longint'(o_data_ready), 1);
        chk("midrst_busy", longint'(o_busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        no_valid("midrst_novalid");
        send(1000, a); wait_out(0, "coeff_reset", a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
